// File: rtl/uart_tx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : uart_tx_engine                                                 |
// | Function : Console-path UART transmitter. A rising edge on tx_req while  |
// |            idle latches tx_data and sends one LSB-first frame: a start   |
// |            bit, 8 data bits and a stop bit, each CLKS_PER_BIT clocks.     |
// |            tx_busy covers the whole frame. All outputs are registered.   |
// | Options  : define UART_TX_PARITY_EN to insert an even-parity bit between |
// |            the last data bit and the stop bit (8E1 framing).             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module uart_tx_engine #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       uart_txd
);

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_START  = 3'd1;
  localparam logic [2:0] c_ST_DATA   = 3'd2;
  localparam logic [2:0] c_ST_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] c_ST_PARITY = 3'd4;
`endif

  // Last count value of each bit period; the counter wraps here.
  localparam logic [15:0] c_BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  // The baud counter is 16 bits wide, so larger dividers cannot be honoured.
  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_cfg
    $error("uart_tx_engine: CLKS_PER_BIT must be in 2..65535");
  end

  logic [2:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        req_prev_q, req_prev_d;
  logic        txd_q, txd_d;
  logic        busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic        par_q, par_d;
`endif

  logic        req_edge;
  logic        bit_tick;

  // Only a fresh 0->1 on tx_req counts; a level held high never retriggers.
  assign req_edge = tx_req & ~req_prev_q;
  assign bit_tick = (baud_q == c_BAUD_LAST);

  // State register: every flop of the engine, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_ST_IDLE;
      baud_q     <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      req_prev_q <= 1'b1;  // a request level held through reset is not an edge
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      req_prev_q <= req_prev_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  // Next-state logic: request acceptance, baud timing and bit sequencing.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    req_prev_d = tx_req;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      c_ST_IDLE: begin
        baud_d = '0;
        if (req_edge) begin
          state_d = c_ST_START;
          shift_d = tx_data;
          idx_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^tx_data;
`endif
        end
      end
      default: begin
        baud_d = bit_tick ? 16'd0 : baud_q + 16'd1;
        if (bit_tick) begin
          case (state_q)
            c_ST_START: begin
              state_d = c_ST_DATA;
              idx_d   = '0;
            end
            c_ST_DATA: begin
              if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_d = c_ST_PARITY;
`else
                state_d = c_ST_STOP;
`endif
              end else begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 3'd1;
              end
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: state_d = c_ST_STOP;
`endif
            c_ST_STOP: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
          endcase
        end
      end
    endcase
  end

  // Output logic: line level and busy flag derived from the upcoming state,
  // so both are registered alongside the state they describe.
  always_comb begin
    busy_d = (state_d != c_ST_IDLE);
    case (state_d)
      c_ST_START:  txd_d = 1'b0;
      c_ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      c_ST_PARITY: txd_d = par_q;
`endif
      default:     txd_d = 1'b1;
    endcase
  end

  assign tx_busy  = busy_q;
  assign uart_txd = txd_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_uart_tx_engine                                              |
// | Function : Scoreboard bench for uart_tx_engine at CLKS_PER_BIT=4. Each    |
// |            request pushes its expected frame (line pattern, busy length, |
// |            start cycle); a negedge monitor pops and checks frames and    |
// |            checks the idle line. Honours UART_TX_PARITY_EN.              |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_uart_tx_engine;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  // {stop, parity, data[7:0], start}
  localparam logic [10:0] P_A5 = 11'b1_0_10100101_0;
  localparam logic [10:0] P_3C = 11'b1_0_00111100_0;
  localparam logic [10:0] P_FF = 11'b1_0_11111111_0;
  localparam logic [10:0] P_00 = 11'b1_0_00000000_0;
  localparam logic [10:0] P_55 = 11'b1_0_01010101_0;
  localparam logic [10:0] P_07 = 11'b1_1_00000111_0;
`else
  localparam int NB = 10;
  // {unused, stop, data[7:0], start}
  localparam logic [10:0] P_A5 = 11'b0_1_10100101_0;
  localparam logic [10:0] P_3C = 11'b0_1_00111100_0;
  localparam logic [10:0] P_FF = 11'b0_1_11111111_0;
  localparam logic [10:0] P_00 = 11'b0_1_00000000_0;
  localparam logic [10:0] P_55 = 11'b0_1_01010101_0;
  localparam logic [10:0] P_07 = 11'b0_1_00000111_0;
`endif
  localparam int BLEN = NB * CPB;

  typedef struct {
    logic [10:0] pat;
    int          blen;
    int          start;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       uart_txd;

  frame_t exp_q[$];
  frame_t cur;
  bit     cur_valid = 1'b0;
  bit     in_frame  = 1'b0;
  bit     mon_en    = 1'b0;
  int     fcyc      = 0;
  int     neg_cnt   = 0;
  int     n_checks  = 0;
  int     n_errors  = 0;

  uart_tx_engine #(.CLKS_PER_BIT(CPB)) dut (
    .clk     (clk),
    .rst     (rst),
    .tx_req  (tx_req),
    .tx_data (tx_data),
    .tx_busy (tx_busy),
    .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s at negedge %0d: got %0d expected %0d", name, neg_cnt, act, exp);
    end
  endtask

  // Monitor: opens a frame when tx_busy rises, samples mid-bit, checks length.
  always @(negedge clk) begin
    neg_cnt = neg_cnt + 1;
    if (mon_en) begin
      if (tx_busy) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          fcyc     = 0;
          if (exp_q.size() == 0) begin
            cur_valid = 1'b0;
            check(1'b0, "unexpected_frame", 1, 0);
          end else begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
            check(neg_cnt == cur.start, "frame_start_cycle", neg_cnt, cur.start);
          end
          check(uart_txd == 1'b0, "start_bit_first_cycle", int'(uart_txd), 0);
        end
        if (cur_valid && (fcyc % CPB) == CPB / 2 && (fcyc / CPB) < NB)
          check(uart_txd == cur.pat[fcyc / CPB], "line_bit",
                int'(uart_txd), int'(cur.pat[fcyc / CPB]));
        fcyc++;
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          if (cur_valid)
            check(fcyc == cur.blen, "busy_length", fcyc, cur.blen);
          cur_valid = 1'b0;
        end
        check(uart_txd == 1'b1, "idle_line_high", int'(uart_txd), 1);
      end
    end
  end

  // Raise tx_req with a byte; the frame should appear two negedges later.
  task automatic send(input logic [7:0] d, input logic [10:0] pat, input int blen);
    frame_t f;
    @(posedge clk); #1;
    tx_data = d;
    tx_req  = 1'b1;
    f.pat   = pat;
    f.blen  = blen;
    f.start = neg_cnt + 2;
    exp_q.push_back(f);
    @(posedge clk); #1;
    tx_data = ~d;  // must not disturb the frame in flight
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst     = 1'b1;
    tx_req  = 1'b0;
    tx_data = 8'h00;
    idle(3);
    mon_en = 1'b1;
    rst    = 1'b0;
    idle(20);
    rst = 1'b1;   // reset while idle must leave the line untouched
    idle(1);
    rst = 1'b0;
    idle(5);

    // Basic frame, request left high afterwards.
    send(8'hA5, P_A5, BLEN);
    idle(50);
    tx_req = 1'b0;
    idle(2);

    // Held request: one frame only.
    send(8'h3C, P_3C, BLEN);
    idle(100);
    tx_req = 1'b0;
    idle(2);

    // Second edge at cycle 10 of the frame is lost.
    send(8'hFF, P_FF, BLEN);
    tx_req = 1'b0;
    idle(8);
    tx_req = 1'b1;
    idle(45);
    tx_req = 1'b0;
    idle(2);
    send(8'h00, P_00, BLEN);
    idle(50);
    tx_req = 1'b0;
    idle(2);

    // Reset during cycle 17 of the frame truncates it; held request stays quiet.
    send(8'h55, P_55, 17);
    idle(16);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(30);
    tx_req = 1'b0;
    idle(3);

    // Odd-weight byte (parity bit 1 when parity is built in).
    send(8'h07, P_07, BLEN);
    idle(50);
    tx_req = 1'b0;
    idle(5);

    check(exp_q.size() == 0, "frames_pending", exp_q.size(), 0);
    check(!in_frame, "frame_open_at_end", int'(in_frame), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
